// File: rtl/l1_trigger_decision.sv
// l1_trigger_decision: L1 output neuron, threshold and dead-time control.
// ReLU + weighted sum + bias -> score; strict threshold -> accept pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid           n1_in..n3_in carry a sample this cycle
//   n1_in..n3_in       signed 16-bit hidden-neuron outputs
//   score_out          signed 26-bit score (holds when no new sample)
//   score_valid        score_out updated this cycle
//   trigger_out        one-cycle accept pulse
//   dead_busy          dead time in progress
//   trig_count         accepts, saturating
//   veto_count         over-threshold scores lost to dead time, saturating
module l1_trigger_decision #(
  parameter logic signed [7:0]  W1       = 8'sd3,
  parameter logic signed [7:0]  W2       = 8'sd2,
  parameter logic signed [7:0]  W3       = 8'sd1,
  parameter logic signed [25:0] BIAS     = -26'sd100,
  parameter logic signed [25:0] THRESH   = 26'sd500,
  parameter int unsigned        DEADTIME = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] n1_in,
  input  logic signed [15:0] n2_in,
  input  logic signed [15:0] n3_in,
  output logic signed [25:0] score_out,
  output logic               score_valid,
  output logic               trigger_out,
  output logic               dead_busy,
  output logic [15:0]        trig_count,
  output logic [15:0]        veto_count
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    DEAD
  } state_t;

  localparam logic [7:0] DT = 8'(DEADTIME);

  state_t state;
  logic [7:0] dcnt;

  logic signed [15:0] r1, r2, r3;
  logic signed [23:0] r1x, r2x, r3x;
  logic signed [23:0] w1x, w2x, w3x;
  logic signed [23:0] p1_d, p2_d, p3_d;
  logic signed [23:0] p1, p2, p3;
  logic               v1;
  logic signed [25:0] score_d;

  logic hit;
  logic fire;
  logic veto;

  // ReLU; the clipped value is never negative, so zero-extend it
  assign r1 = n1_in[15] ? 16'sd0 : n1_in;
  assign r2 = n2_in[15] ? 16'sd0 : n2_in;
  assign r3 = n3_in[15] ? 16'sd0 : n3_in;

  assign r1x = {8'd0, r1};
  assign r2x = {8'd0, r2};
  assign r3x = {8'd0, r3};

  assign w1x = {{16{W1[7]}}, W1};
  assign w2x = {{16{W2[7]}}, W2};
  assign w3x = {{16{W3[7]}}, W3};

  assign p1_d = r1x * w1x;
  assign p2_d = r2x * w2x;
  assign p3_d = r3x * w3x;

  assign score_d = {{2{p1[23]}}, p1}
                 + {{2{p2[23]}}, p2}
                 + {{2{p3[23]}}, p3}
                 + BIAS;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      v1 <= 1'b0;
    end else begin
      p1 <= p1_d;
      p2 <= p2_d;
      p3 <= p3_d;
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_out   <= '0;
      score_valid <= 1'b0;
    end else begin
      score_valid <= v1;
      if (v1) begin
        score_out <= score_d;
      end
    end
  end

  assign hit = score_valid && (score_out > THRESH);

  // fire: next cycle is an accept; veto: a hit swallowed by dead time
  always_comb begin
    fire = 1'b0;
    veto = 1'b0;
    unique case (state)
      IDLE: fire = hit;
      FIRE: begin
        fire = hit && (DT == 8'd0);
        veto = hit && (DT != 8'd0);
      end
      DEAD: veto = hit;
      default: begin
        fire = 1'b0;
        veto = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      trigger_out <= 1'b0;
      dead_busy   <= 1'b0;
    end else begin
      trigger_out <= fire;
      unique case (state)
        IDLE: begin
          if (fire) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          if (DT == 8'd0) begin
            state <= fire ? FIRE : IDLE;
          end else begin
            dcnt      <= DT;
            dead_busy <= 1'b1;
            state     <= DEAD;
          end
        end
        DEAD: begin
          dcnt <= dcnt - 8'd1;
          if (dcnt == 8'd1) begin
            dead_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          dead_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // counters are rewritten every cycle and stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_count <= '0;
      veto_count <= '0;
    end else begin
      trig_count <= (fire && trig_count != 16'hFFFF)
                  ? trig_count + 16'd1 : trig_count;
      veto_count <= (veto && veto_count != 16'hFFFF)
                  ? veto_count + 16'd1 : veto_count;
    end
  end

endmodule

// File: tb/tb_l1_trigger_decision.sv
// tb_l1_trigger_decision: scoreboard bench for l1_trigger_decision.
// Directed threshold, dead-time, reset and saturation cases plus random traffic.
module tb_l1_trigger_decision;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] n1, n2, n3;
  logic signed [25:0] score_out;
  logic               score_valid;
  logic               trigger_out;
  logic               dead_busy;
  logic [15:0]        trig_count;
  logic [15:0]        veto_count;

  l1_trigger_decision dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .n1_in       (n1),
    .n2_in       (n2),
    .n3_in       (n3),
    .score_out   (score_out),
    .score_valid (score_valid),
    .trigger_out (trigger_out),
    .dead_busy   (dead_busy),
    .trig_count  (trig_count),
    .veto_count  (veto_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int escore(input int a, input int b, input int c);
    int ra, rb, rc;
    ra = (a < 0) ? 0 : a;
    rb = (b < 0) ? 0 : b;
    rc = (c < 0) ? 0 : c;
    return 3 * ra + 2 * rb + rc - 100;
  endfunction

  // reference model state
  int q[$];
  bit mv1, mv2;
  int msc;
  int mst;
  int mdc;
  bit mtrig, mdead;
  int mtc, mvc;
  int ntrig, ndead;

  task automatic step();
    bit hit;
    bit iv;
    bit r;
    int e;
    hit = mv2 && (msc > 500);
    iv  = in_valid;
    r   = rst;
    e   = escore(int'(n1), int'(n2), int'(n3));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mv1 = 0; mv2 = 0; msc = 0;
      mst = 0; mdc = 0; mtrig = 0; mdead = 0;
      mtc = 0; mvc = 0;
    end else begin
      mtrig = 0;
      case (mst)
        0: if (hit) begin
          mst = 1; mtrig = 1;
          if (mtc < 65535) mtc++;
        end
        1: begin
          if (hit && mvc < 65535) mvc++;
          mst = 2; mdc = 4; mdead = 1;
        end
        default: begin
          if (hit && mvc < 65535) mvc++;
          if (mdc == 1) begin
            mst = 0; mdead = 0;
          end
          mdc--;
        end
      endcase
      if (iv) q.push_back(e);
      mv2 = mv1;
      mv1 = iv;
      if (mv2) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          msc = q.pop_front();
        end
      end
    end
    if (trigger_out) ntrig++;
    if (dead_busy) ndead++;
    chk("score_valid", score_valid, mv2);
    chk("score_out", score_out, msc);
    chk("trigger_out", trigger_out, mtrig);
    chk("dead_busy", dead_busy, mdead);
    chk("trig_count", trig_count, mtc);
    chk("veto_count", veto_count, mvc);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int a, input int b, input int c);
    n1 = 16'(a);
    n2 = 16'(b);
    n3 = 16'(c);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    n1 = '0; n2 = '0; n3 = '0;
    ntrig = 0; ndead = 0;

    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom);
      n1 = 16'($urandom);
      n2 = 16'($urandom);
      n3 = 16'($urandom);
      step();
    end
    chk("rst_score", score_out, 0);
    chk("rst_sv", score_valid, 0);
    chk("rst_trig", trigger_out, 0);
    chk("rst_dead", dead_busy, 0);
    chk("rst_tcnt", trig_count, 0);
    chk("rst_vcnt", veto_count, 0);
    rst = 1'b0;
    ntrig = 0;
    idle(3);
    chk("rst_no_trig", ntrig, 0);

    send(100, 50, -20);
    step();
    chk("below_sv", score_valid, 1);
    chk("below_score", score_out, 300);
    idle(4);
    chk("below_no_trig", ntrig, 0);

    send(200, 0, 0);
    step();
    chk("eq_score", score_out, 500);
    idle(4);
    chk("eq_no_trig", ntrig, 0);

    send(200, 1, 0);
    step();
    chk("fire_score", score_out, 502);
    step();
    chk("fire_pulse", trigger_out, 1);
    chk("fire_tcnt", trig_count, 1);
    step();
    chk("fire_pulse_end", trigger_out, 0);
    idle(8);
    chk("fire_one_pulse", ntrig, 1);

    ntrig = 0;
    ndead = 0;
    n1 = 16'sd200; n2 = 16'sd100; n3 = 16'sd0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    chk("dead_veto5", veto_count, 5);
    chk("dead_len", ndead, 4);
    chk("dead_one_trig", ntrig, 1);
    step();
    chk("dead_refire", trigger_out, 1);
    chk("dead_tcnt", trig_count, 3);
    idle(8);
    chk("dead_trigs", ntrig, 2);
    chk("dead_len2", ndead, 8);

    send(200, 1, 0);
    idle(2);
    step();
    chk("mid_dead_on", dead_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_dead_off", dead_busy, 0);
    chk("mid_tcnt", trig_count, 0);
    chk("mid_vcnt", veto_count, 0);
    chk("mid_sv", score_valid, 0);
    send(200, 1, 0);
    step();
    step();
    chk("mid_refire", trigger_out, 1);
    idle(8);

    for (int i = 0; i < 60; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      n1 = 16'($signed($urandom_range(0, 700)) - 200);
      n2 = 16'($signed($urandom_range(0, 400)) - 100);
      n3 = 16'($signed($urandom_range(0, 400)) - 100);
      step();
    end
    idle(10);

    force dut.trig_count = 16'hFFFE;
    mtc = 16'hFFFE;
    step();
    release dut.trig_count;
    for (int i = 0; i < 3; i++) begin
      send(200, 1, 0);
      idle(9);
    end
    chk("sat_tcnt", trig_count, 16'hFFFF);

    force dut.veto_count = 16'hFFFE;
    mvc = 16'hFFFE;
    step();
    release dut.veto_count;
    n1 = 16'sd200; n2 = 16'sd100; n3 = 16'sd0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    idle(10);
    chk("sat_vcnt", veto_count, 16'hFFFF);
    chk("sat_tcnt_hold", trig_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
